// File: rtl/case_stream_conv.sv
// Streaming multi-lane ASCII case converter: pass/upper/lower/toggle/title modes,
// one registered output slice and a saturating count of modified bytes.
module case_stream_conv #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         mode,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [8*LANES-1:0] s_data,
   input  logic [LANES-1:0]   s_keep,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [8*LANES-1:0] m_data,
   output logic [LANES-1:0]   m_keep,
   output logic               m_last,
   input  logic               clr_count,
   output logic [CNT_W-1:0]   conv_count
);
   localparam int         INC_W       = $clog2(LANES + 1);
   localparam logic [2:0] MODE_UPPER  = 3'd1;
   localparam logic [2:0] MODE_LOWER  = 3'd2;
   localparam logic [2:0] MODE_TOGGLE = 3'd3;
   localparam logic [2:0] MODE_TITLE  = 3'd4;

   logic               m_valid_q, m_valid_d;
   logic [8*LANES-1:0] m_data_q, m_data_d;
   logic [LANES-1:0]   m_keep_q, m_keep_d;
   logic               m_last_q, m_last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               at_bnd_q, at_bnd_d;
   logic               at_pkt_start_q, at_pkt_start_d;
   logic [2:0]         mode_q, mode_d;

   logic               accept;
   logic [2:0]         eff_mode;
   logic [8*LANES-1:0] conv_data;
   logic [INC_W-1:0]   inc;
   logic               bnd_out;
   logic [CNT_W:0]     cnt_sum;

   // Handshake: a beat moves on s_* when s_valid & s_ready, and on m_* when
   // m_valid & m_ready; the slice accepts whenever it is empty or draining.
   assign s_ready  = rst_n & (~m_valid_q | m_ready);
   assign accept   = s_valid & s_ready;
   assign eff_mode = at_pkt_start_q ? mode : mode_q;

   always_comb begin : conv_comb
      logic       bnd;
      logic [7:0] b;
      logic [7:0] o;
      logic       is_up;
      logic       is_lo;
      bnd       = at_bnd_q;
      b         = '0;
      o         = '0;
      is_up     = 1'b0;
      is_lo     = 1'b0;
      conv_data = '0;
      inc       = '0;
      for (int i = 0; i < LANES; i++) begin
         b     = s_data[8*i +: 8];
         is_up = (b >= 8'h41) && (b <= 8'h5A);
         is_lo = (b >= 8'h61) && (b <= 8'h7A);
         o     = b;
         case (eff_mode)
            MODE_UPPER:  if (is_lo) o = b ^ 8'h20;
            MODE_LOWER:  if (is_up) o = b ^ 8'h20;
            MODE_TOGGLE: if (is_up || is_lo) o = b ^ 8'h20;
            MODE_TITLE:  if ((bnd && is_lo) || (!bnd && is_up)) o = b ^ 8'h20;
            default:     o = b;
         endcase
         // Dropped lanes neither emit data nor advance the word-boundary chain.
         if (s_keep[i]) begin
            conv_data[8*i +: 8] = o;
            if (o != b) inc = inc + INC_W'(1);
            bnd = (b == 8'h20) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
         end
      end
      bnd_out = bnd;
   end

   always_comb begin
      m_valid_d      = m_valid_q;
      m_data_d       = m_data_q;
      m_keep_d       = m_keep_q;
      m_last_d       = m_last_q;
      at_bnd_d       = at_bnd_q;
      at_pkt_start_d = at_pkt_start_q;
      mode_d         = mode_q;
      cnt_d          = cnt_q;
      cnt_sum        = {1'b0, cnt_q} + (CNT_W+1)'(inc);
      if (accept) begin
         m_valid_d      = 1'b1;
         m_data_d       = conv_data;
         m_keep_d       = s_keep;
         m_last_d       = s_last;
         at_bnd_d       = s_last | bnd_out;
         at_pkt_start_d = s_last;
         if (at_pkt_start_q) mode_d = mode;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
      if (clr_count) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_keep_q       <= '0;
         m_last_q       <= 1'b0;
         cnt_q          <= '0;
         at_bnd_q       <= 1'b1;
         at_pkt_start_q <= 1'b1;
         mode_q         <= '0;
      end else begin
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_keep_q       <= m_keep_d;
         m_last_q       <= m_last_d;
         cnt_q          <= cnt_d;
         at_bnd_q       <= at_bnd_d;
         at_pkt_start_q <= at_pkt_start_d;
         mode_q         <= mode_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_keep     = m_keep_q;
   assign m_last     = m_last_q;
   assign conv_count = cnt_q;
endmodule

// File: tb/tb_case_stream_conv.sv
// Bench for case_stream_conv: directed vector table, multi-cycle corner sequences
// and a randomized run against a byte-level reference model.
module tb_case_stream_conv;
   localparam int LANES = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [2:0]          mode;
   logic                s_valid;
   logic                s_ready;
   logic [8*LANES-1:0]  s_data;
   logic [LANES-1:0]    s_keep;
   logic                s_last;
   logic                m_valid;
   logic                m_ready;
   logic [8*LANES-1:0]  m_data;
   logic [LANES-1:0]    m_keep;
   logic                m_last;
   logic                clr_count;
   logic [CNT_W-1:0]    conv_count;

   int n_vec = 0;
   int n_err = 0;

   case_stream_conv #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
      .clr_count(clr_count), .conv_count(conv_count)
   );

   // ---- clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---- reference model (byte-by-byte from the case rules)
   logic [36:0] exp_q[$];
   logic        m_bnd;
   logic        m_start;
   logic [2:0]  m_mode;
   int          model_cnt;

   task automatic ref_beat(input logic [2:0] md, input logic [31:0] din, input logic [3:0] kin,
                           output logic [31:0] dout, output int nchg);
      logic [7:0] b;
      logic [7:0] o;
      logic       up;
      logic       lo;
      dout = '0;
      nchg = 0;
      for (int i = 0; i < LANES; i++) begin
         if (kin[i]) begin
            b  = din[8*i +: 8];
            up = (b >= "A") && (b <= "Z");
            lo = (b >= "a") && (b <= "z");
            o  = b;
            case (md)
               3'd1: if (lo) o = b - 8'd32;
               3'd2: if (up) o = b + 8'd32;
               3'd3: begin
                  if (up) o = b + 8'd32;
                  else if (lo) o = b - 8'd32;
               end
               3'd4: begin
                  if (m_bnd && lo) o = b - 8'd32;
                  else if (!m_bnd && up) o = b + 8'd32;
               end
               default: o = b;
            endcase
            m_bnd = (b == " ") || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
            dout[8*i +: 8] = o;
            if (o != b) nchg++;
         end
      end
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] r;
      case ($urandom_range(0, 7))
         0, 1, 2: r = 8'(8'h61 + $urandom_range(0, 25));
         3, 4:    r = 8'(8'h41 + $urandom_range(0, 25));
         5: begin
            case ($urandom_range(0, 3))
               0: r = 8'h20;
               1: r = 8'h09;
               2: r = 8'h0A;
               default: r = 8'h0D;
            endcase
         end
         6:       r = 8'($urandom_range(0, 255));
         default: r = 8'(8'h80 + $urandom_range(0, 127));
      endcase
      return r;
   endfunction

   // ---- driver for single directed beats with m_ready held high
   task automatic apply_beat(input string nm, input logic [2:0] md, input logic [31:0] din,
                             input logic [3:0] kp, input logic lst, input logic clr,
                             input logic [31:0] dout, input logic [3:0] cnt);
      mode = md; s_data = din; s_keep = kp; s_last = lst; clr_count = clr;
      m_ready = 1'b1; s_valid = 1'b1;
      #1;
      cmp({nm, "_s_ready"}, s_ready, 1'b1);
      tick();
      s_valid = 1'b0; clr_count = 1'b0;
      cmp({nm, "_m_valid"}, m_valid, 1'b1);
      cmp({nm, "_m_data"}, m_data, dout);
      cmp({nm, "_m_keep"}, m_keep, kp);
      cmp({nm, "_m_last"}, m_last, lst);
      cmp({nm, "_count"}, conv_count, cnt);
   endtask

   typedef struct {
      logic [2:0]  md;
      logic [31:0] din;
      logic [3:0]  kp;
      logic        lst;
      logic [31:0] dout;
      logic [3:0]  cnt;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic        have_beat;
      logic        acc;
      logic [2:0]  md_eff;
      logic [31:0] dout;
      int          nchg;
      logic [36:0] e;

      tbl[0]  = '{3'd1, 32'h487B7A61, 4'hF, 1'b1, 32'h487B5A41, 4'd2};
      tbl[1]  = '{3'd2, 32'h31436241, 4'hF, 1'b1, 32'h31636261, 4'd4};
      tbl[2]  = '{3'd0, 32'h31436241, 4'hF, 1'b1, 32'h31436241, 4'd4};
      tbl[3]  = '{3'd3, 32'h6241B7EB, 4'hB, 1'b1, 32'h4200B7EB, 4'd5};
      tbl[4]  = '{3'd5, 32'h7A7A7A7A, 4'hF, 1'b1, 32'h7A7A7A7A, 4'd5};
      tbl[5]  = '{3'd4, 32'h4C4C4568, 4'hF, 1'b0, 32'h6C6C6548, 4'd9};
      tbl[6]  = '{3'd4, 32'h4F77206F, 4'hF, 1'b1, 32'h6F57206F, 4'd11};
      tbl[7]  = '{3'd4, 32'h64636261, 4'hF, 1'b1, 32'h64636241, 4'd12};
      tbl[8]  = '{3'd1, 32'h61616161, 4'h0, 1'b1, 32'h00000000, 4'd12};
      tbl[9]  = '{3'd4, 32'h62410A61, 4'hB, 1'b1, 32'h42000A41, 4'd14};
      tbl[10] = '{3'd4, 32'h4261C320, 4'hF, 1'b1, 32'h6261C320, 4'd15};
      tbl[11] = '{3'd1, 32'h7A7A7A7A, 4'hF, 1'b1, 32'h5A5A5A5A, 4'd15};

      rst_n = 1'b0; mode = '0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
      m_ready = 1'b0; clr_count = 1'b0;
      repeat (3) tick();
      cmp("rst_s_ready", s_ready, 1'b0);
      cmp("rst_m_valid", m_valid, 1'b0);
      cmp("rst_m_data", m_data, 32'h0);
      cmp("rst_m_keep", m_keep, 4'h0);
      cmp("rst_m_last", m_last, 1'b0);
      cmp("rst_count", conv_count, 4'd0);
      rst_n = 1'b1;
      #1;
      cmp("post_rst_s_ready", s_ready, 1'b1);

      // ---- directed vector table
      for (int i = 0; i < 12; i++)
         apply_beat($sformatf("tbl%0d", i), tbl[i].md, tbl[i].din, tbl[i].kp, tbl[i].lst,
                    1'b0, tbl[i].dout, tbl[i].cnt);

      // ---- clear coincident with an accept discards that beat's increment
      apply_beat("clr_acc", 3'd1, 32'h61616161, 4'hF, 1'b1, 1'b1, 32'h41414141, 4'd0);
      apply_beat("after_clr", 3'd3, 32'h41414141, 4'hF, 1'b1, 1'b0, 32'h61616161, 4'd4);

      // ---- mode latched for the whole packet, first beat uses the live mode
      apply_beat("latch_b1", 3'd1, 32'h64636261, 4'hF, 1'b0, 1'b0, 32'h44434241, 4'd8);
      apply_beat("latch_b2", 3'd2, 32'h68676665, 4'hF, 1'b1, 1'b0, 32'h48474645, 4'd12);
      apply_beat("latch_nxt", 3'd2, 32'h4C4B4A49, 4'hF, 1'b1, 1'b0, 32'h6C6B6A69, 4'd15);

      // ---- backpressure: output held while m_ready is low
      mode = 3'd1; s_data = 32'h64636261; s_keep = 4'hF; s_last = 1'b0; s_valid = 1'b1;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0; s_data = 32'h68676665;
      for (int k = 0; k < 3; k++) begin
         #1;
         cmp("bp_s_ready", s_ready, 1'b0);
         cmp("bp_hold_data", m_data, 32'h44434241);
         tick();
      end
      cmp("bp_hold_valid", m_valid, 1'b1);
      cmp("bp_hold_data2", m_data, 32'h44434241);
      m_ready = 1'b1;
      #1;
      cmp("bp_release_ready", s_ready, 1'b1);
      tick();
      cmp("bp_beat2", m_data, 32'h48474645);
      s_data = 32'h6C6B6A69; s_last = 1'b1;
      tick();
      cmp("bp_beat3", m_data, 32'h4C4B4A49);
      cmp("bp_beat3_last", m_last, 1'b1);
      s_valid = 1'b0;
      tick();
      cmp("bp_drained", m_valid, 1'b0);

      // ---- reset in the middle of a packet with a held beat
      m_ready = 1'b0; mode = 3'd1; s_data = 32'h777A7978; s_keep = 4'hF; s_last = 1'b0;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      cmp("mid_held", m_valid, 1'b1);
      rst_n = 1'b0;
      tick();
      cmp("mid_rst_valid", m_valid, 1'b0);
      cmp("mid_rst_data", m_data, 32'h0);
      cmp("mid_rst_keep", m_keep, 4'h0);
      cmp("mid_rst_last", m_last, 1'b0);
      cmp("mid_rst_count", conv_count, 4'd0);
      cmp("mid_rst_ready", s_ready, 1'b0);
      rst_n = 1'b1;
      apply_beat("rst_title", 3'd4, 32'h00006261, 4'h3, 1'b1, 1'b0, 32'h00006241, 4'd1);
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      cmp("pre_rand_count", conv_count, 4'd0);
      cmp("pre_rand_valid", m_valid, 1'b0);

      // ---- randomized traffic vs reference model
      m_bnd = 1'b1; m_start = 1'b1; m_mode = '0; model_cnt = 0;
      have_beat = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!have_beat && $urandom_range(0, 3) != 0) begin
            mode = 3'($urandom_range(0, 7));
            for (int i = 0; i < LANES; i++) s_data[8*i +: 8] = rand_byte();
            s_keep = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            s_last = ($urandom_range(0, 2) == 0);
            have_beat = 1'b1;
         end
         s_valid   = have_beat;
         m_ready   = ($urandom_range(0, 3) != 0);
         clr_count = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         cmp("rnd_m_valid", m_valid, exp_q.size() != 0);
         cmp("rnd_s_ready", s_ready, (exp_q.size() == 0) || m_ready);
         if (m_valid && m_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("rnd_m_data", m_data, e[31:0]);
            cmp("rnd_m_keep", m_keep, e[35:32]);
            cmp("rnd_m_last", m_last, e[36]);
         end
         cmp("rnd_count", conv_count, model_cnt);
         acc  = s_valid && s_ready;
         nchg = 0;
         if (acc) begin
            md_eff = m_start ? mode : m_mode;
            if (m_start) m_mode = mode;
            ref_beat(md_eff, s_data, s_keep, dout, nchg);
            if (s_last) begin
               m_bnd   = 1'b1;
               m_start = 1'b1;
            end else begin
               m_start = 1'b0;
            end
            exp_q.push_back({s_last, s_keep, dout});
            have_beat = 1'b0;
         end
         if (clr_count) model_cnt = 0;
         else if (acc) model_cnt = (model_cnt + nchg > CMAX) ? CMAX : model_cnt + nchg;
         @(posedge clk);
         #1;
      end

      // ---- drain with a bounded cycle budget
      s_valid = 1'b0; m_ready = 1'b1; clr_count = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (m_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("drain_m_data", m_data, e[31:0]);
         end
         @(posedge clk);
         #1;
      end
      cmp("drain_empty", exp_q.size(), 0);
      cmp("drain_m_valid", m_valid, 1'b0);
      cmp("final_count", conv_count, model_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
